cp0_timer_ctrl: RTL and testbench
=================================

CP0_TIMER_CTRL -- requirements
Module: cp0_timer_ctrl

Interface
REQ-001 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port cp0_we  input  1  CP0 write strobe from pipeline (mtc0).
REQ-004 SHALL have port cp0_waddr  input  5  CP0 write register number.
REQ-005 SHALL have port cp0_wdata  input  32  CP0 write data.
REQ-006 SHALL have port cp0_raddr  input  5  CP0 read register number (mfc0).
REQ-007 SHALL have port cp0_rdata  output  32  combinational read data.
REQ-008 SHALL have port int_en  input  1  Status.IE & Status.IM7 & !Status.EXL, from CP0 status logic.
REQ-009 SHALL have port irq  output  1  timer interrupt request to the exception unit.
REQ-010 SHALL have port irq_ack  input  1  exception unit has taken the timer interrupt.
REQ-011 SHALL have port ip7  output  1  Cause.IP7 pending bit.

Function
REQ-012 SHALL implement Count at register 9 and Compare at register 11; a read of any other address returns 32'h0.
REQ-013 SHALL apply the write on the clock edge after cp0_we is sampled; a read in the same cycle returns the old value.
REQ-014 SHALL increment Count by 1 on each tick, modulo 2^32 (32'hFFFFFFFF -> 32'h0), with no overflow flag.
REQ-015 SHALL raise a match event only on a tick where Count+1 == Compare.
REQ-016 SHALL NOT raise a match when Count is written equal to Compare or Compare is written equal to Count.
REQ-017 SHALL write Count in place of that cycle's increment.
REQ-018 SHALL run a four-state FSM with states IDLE, PEND, REQ and DONE.
REQ-019 SHALL transition IDLE -> PEND on a match.
REQ-020 SHALL transition PEND -> REQ when int_en == 1.
REQ-021 SHALL transition REQ -> DONE on irq_ack.
REQ-022 SHALL transition REQ -> PEND if int_en drops while irq_ack == 0.
REQ-023 SHALL leave DONE only on a Compare write.
REQ-024 SHALL drive irq = (state == REQ), registered.
REQ-025 SHALL drive ip7 = 1 in PEND, REQ and DONE.
REQ-026 SHALL force the next state to IDLE on a Compare write from any state; this takes priority over a same-cycle match and over a same-cycle irq_ack.
REQ-027 SHALL ignore irq_ack outside REQ.
REQ-028 SHALL leave the FSM unchanged on a Count write.

Reset
REQ-029 SHALL on rst set Count = 0, Compare = 0, tick phase = 0, state = IDLE, irq = 0 and ip7 = 0.
REQ-030 SHALL give rst priority over every write, match and ack.
REQ-031 SHALL abandon an outstanding request when rst is asserted mid-REQ, with irq low from the next cycle.
REQ-032 SHALL produce no match on the first post-reset tick, since 0+1 != 0.

Configuration
REQ-033 SHALL, when macro CP0_COUNT_DIV2_EN is defined, tick every second cycle via a phase bit; Count increments when phase == 1, and a Count write clears phase.
REQ-034 SHALL, when CP0_COUNT_DIV2_EN is undefined, tick every cycle with no phase bit.

Structure
REQ-035 SHALL take CP0 register numbers (CP0_COUNT = 9, CP0_COMPARE = 11) and the FSM state encoding from shared package cp0_pkg.
REQ-036 SHALL place Count and its tick logic in a sub-module cp0_count, with outputs count and tick; the FSM, Compare register and read mux stay in the top module.

Verification
REQ-037 SHALL verify: write Compare = 5 with Count = 0 and int_en = 1, no DIV2 -> irq rises in the cycle after Count reaches 5, ip7 = 1.
REQ-038 SHALL verify: in REQ, pulse irq_ack -> irq = 0 next cycle and ip7 stays 1; write Compare = 20 -> ip7 = 0 next cycle.
REQ-039 SHALL verify: write Count = 32'hFFFFFFFE and Compare = 0 -> Count wraps to 0, match fires, state = PEND with int_en = 0 and irq = 0; raise int_en -> irq = 1.
REQ-040 SHALL verify: Compare write in the same cycle as a match -> state stays IDLE and ip7 = 0.
REQ-041 SHALL verify: rst pulsed while irq = 1 -> irq = 0, Count = 0 and Compare = 0 next cycle; mfc0 reg 9 returns 0.
REQ-042 SHALL verify, with CP0_COUNT_DIV2_EN: 10 cycles after reset -> Count = 5; Compare = 3 -> match after 6 cycles.

Source files
------------

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register numbers and timer FSM state encoding
package cp0_pkg;
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    typedef enum logic [1:0] {IDLE, PEND, REQ, DONE} tmr_state_t;
endpackage

// File: rtl/cp0_count.sv
// cp0_count: free-running CP0 Count register with optional divide-by-2 tick
// Ports: clk, rst (sync, active-high); we/wdata load Count in place of the
// increment; count is the register value; tick is high when count advances
// at the coming edge. Macro CP0_COUNT_DIV2_EN: advance every second cycle.
module cp0_count (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic        tick
);
`ifdef CP0_COUNT_DIV2_EN
    logic phase;
    always_ff @(posedge clk)
        phase <= (rst || we) ? 1'b0 : ~phase;
    assign tick = phase & ~we;
`else
    assign tick = ~we;
`endif
    always_ff @(posedge clk)
        if (rst)
            count <= 32'h0;
        else if (we)
            count <= wdata;
        else if (tick)
            count <= count + 32'd1;
endmodule

// File: rtl/cp0_timer_ctrl.sv
// cp0_timer_ctrl: CP0 Count/Compare timer with interrupt request FSM
// Ports: clk, rst (sync, active-high); cp0_we/cp0_waddr/cp0_wdata mtc0 write;
// cp0_raddr/cp0_rdata combinational mfc0 read (9 Count, 11 Compare, else 0);
// int_en interrupt enable; irq request to exception unit; irq_ack its accept;
// ip7 Cause.IP7 pending. Macro CP0_COUNT_DIV2_EN: Count ticks every 2 cycles.
module cp0_timer_ctrl
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic        int_en,
    output logic        irq,
    input  logic        irq_ack,
    output logic        ip7
);
    logic [31:0] count, compare;
    logic        tick, count_we, compare_we, match;
    tmr_state_t  state, state_nxt;

    assign count_we   = cp0_we && cp0_waddr == CP0_COUNT;
    assign compare_we = cp0_we && cp0_waddr == CP0_COMPARE;

    cp0_count u_count (
        .clk   (clk),
        .rst   (rst),
        .we    (count_we),
        .wdata (cp0_wdata),
        .count (count),
        .tick  (tick)
    );

    // Only a real increment can match; writes landing on equality never do.
    assign match = tick && (count + 32'd1) == compare;

    always_ff @(posedge clk)
        if (rst)
            compare <= 32'h0;
        else if (compare_we)
            compare <= cp0_wdata;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = match ? PEND : IDLE;
            PEND: state_nxt = int_en ? REQ : PEND;
            REQ:  state_nxt = irq_ack ? DONE : (int_en ? REQ : PEND);
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        // A Compare write clears the interrupt, beating any match or ack.
        if (compare_we)
            state_nxt = IDLE;
    end

    assign irq = state == REQ;
    assign ip7 = state != IDLE;

    assign cp0_rdata = cp0_raddr == CP0_COUNT   ? count   :
                       cp0_raddr == CP0_COMPARE ? compare : 32'h0;
endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// tb_cp0_timer_ctrl: randomized and directed check of cp0_timer_ctrl against a reference model
module tb_cp0_timer_ctrl;
    logic        clk = 1'b0, rst = 1'b1, cp0_we = 1'b0, int_en = 1'b0, irq_ack = 1'b0;
    logic [4:0]  cp0_waddr = 5'd0, cp0_raddr = 5'd0;
    logic [31:0] cp0_wdata = 32'h0, cp0_rdata;
    logic        irq, ip7;
    int          n_vec = 0, n_err = 0;

    // Reference model: st 0 idle, 1 pending, 2 requesting, 3 taken
    logic [31:0] m_cnt, m_cmp;
    bit          m_ph;
    int          m_st;

    always #5 clk = ~clk;

    cp0_timer_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cp0_we    (cp0_we),
        .cp0_waddr (cp0_waddr),
        .cp0_wdata (cp0_wdata),
        .cp0_raddr (cp0_raddr),
        .cp0_rdata (cp0_rdata),
        .int_en    (int_en),
        .irq       (irq),
        .irq_ack   (irq_ack),
        .ip7       (ip7)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit we, input logic [4:0] wa,
                              input logic [31:0] wd, input bit ie, input bit ack);
        bit cw, kw, adv, hit;
        if (r) begin
            m_cnt = 0; m_cmp = 0; m_ph = 0; m_st = 0;
            return;
        end
        cw = we && wa == 5'd9;
        kw = we && wa == 5'd11;
`ifdef CP0_COUNT_DIV2_EN
        adv = !cw && m_ph;
        m_ph = cw ? 1'b0 : !m_ph;
`else
        adv = !cw;
`endif
        hit = adv && (m_cnt + 32'd1 == m_cmp);
        if (kw) m_st = 0;
        else if (m_st == 0 && hit) m_st = 1;
        else if (m_st == 1 && ie) m_st = 2;
        else if (m_st == 2 && ack) m_st = 3;
        else if (m_st == 2 && !ie) m_st = 1;
        m_cnt = cw ? wd : m_cnt + (adv ? 32'd1 : 32'd0);
        if (kw) m_cmp = wd;
    endtask

    task automatic apply(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input bit ie, input bit ack);
        rst = r; cp0_we = we; cp0_waddr = wa; cp0_wdata = wd;
        cp0_raddr = ra; int_en = ie; irq_ack = ack;
        #4;
        chk("rdata", cp0_rdata, ra == 5'd9 ? m_cnt : ra == 5'd11 ? m_cmp : 32'h0);
        chk("irq", {31'b0, irq}, {31'b0, m_st == 2});
        chk("ip7", {31'b0, ip7}, {31'b0, m_st != 0});
        model_step(r, we, wa, wd, ie, ack);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ie);
        for (int i = 0; i < n; i++) apply(0, 0, 5'd0, 32'h0, 5'd9, ie, 0);
    endtask

    task automatic read_chk(input string tag, input logic [4:0] ra, input logic [31:0] exp);
        cp0_raddr = ra;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    initial begin
        bit r, we, ie, ack;
        logic [4:0] wa, ra;
        logic [31:0] wd;
        int n;
        @(posedge clk);
        #1;
        model_step(1, 0, 0, 0, 0, 0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_ip7", {31'b0, ip7}, 32'h0);
        read_chk("rst_count", 5'd9, 32'h0);
        read_chk("rst_compare", 5'd11, 32'h0);
`ifndef CP0_COUNT_DIV2_EN
        apply(0, 1, 5'd11, 32'd5, 5'd9, 1, 0);
        idle(4, 1);
        chk("m5_ip7", {31'b0, ip7}, 32'h1);
        chk("m5_irq_low", {31'b0, irq}, 32'h0);
        read_chk("m5_count", 5'd9, 32'd5);
        idle(1, 1);
        chk("m5_irq", {31'b0, irq}, 32'h1);
        apply(0, 0, 5'd0, 32'h0, 5'd9, 1, 1);
        chk("ack_irq", {31'b0, irq}, 32'h0);
        chk("ack_ip7", {31'b0, ip7}, 32'h1);
        idle(2, 1);
        chk("done_hold", {31'b0, ip7}, 32'h1);
        apply(0, 1, 5'd11, 32'd20, 5'd9, 1, 0);
        chk("cmpw_ip7", {31'b0, ip7}, 32'h0);
        apply(0, 1, 5'd9, 32'hFFFF_FFFE, 5'd9, 0, 0);
        apply(0, 1, 5'd11, 32'h0, 5'd9, 0, 0);
        read_chk("wrap_pre", 5'd9, 32'hFFFF_FFFF);
        idle(1, 0);
        read_chk("wrap_cnt", 5'd9, 32'h0);
        chk("wrap_ip7", {31'b0, ip7}, 32'h1);
        chk("wrap_irq", {31'b0, irq}, 32'h0);
        idle(1, 1);
        chk("wrap_ie_irq", {31'b0, irq}, 32'h1);
        apply(0, 1, 5'd11, 32'd200, 5'd9, 1, 0);
        apply(0, 1, 5'd9, 32'd199, 5'd9, 1, 0);
        apply(0, 1, 5'd11, 32'd300, 5'd9, 1, 0);
        chk("race_ip7", {31'b0, ip7}, 32'h0);
        idle(2, 1);
        chk("race_idle", {31'b0, ip7}, 32'h0);
        n = 0;
        while (!irq && n < 300) begin
            idle(1, 1);
            n++;
        end
        chk("irq_wait", {31'b0, irq}, 32'h1);
        apply(1, 1, 5'd11, 32'd7, 5'd9, 1, 1);
        chk("rst_req_irq", {31'b0, irq}, 32'h0);
        read_chk("rst_req_cnt", 5'd9, 32'h0);
        read_chk("rst_req_cmp", 5'd11, 32'h0);
`else
        apply(1, 0, 5'd0, 32'h0, 5'd9, 0, 0);
        apply(0, 1, 5'd11, 32'd3, 5'd9, 1, 0);
        idle(4, 1);
        chk("d2_nomatch", {31'b0, ip7}, 32'h0);
        idle(1, 1);
        chk("d2_match", {31'b0, ip7}, 32'h1);
        apply(1, 0, 5'd0, 32'h0, 5'd9, 0, 0);
        idle(10, 0);
        read_chk("d2_count5", 5'd9, 32'd5);
`endif
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99) == 0;
            we = $urandom_range(0, 3) == 0;
            n  = $urandom_range(0, 3);
            wa = n == 0 ? 5'd9 : n < 3 ? 5'd11 : 5'($urandom);
            wd = $urandom_range(0, 1) ? m_cnt + 32'($urandom_range(0, 12)) : 32'($urandom);
            n  = $urandom_range(0, 2);
            ra = n == 0 ? 5'd9 : n == 1 ? 5'd11 : 5'($urandom);
            ie = $urandom_range(0, 3) != 0;
            ack = $urandom_range(0, 2) == 0;
            apply(r, we, wa, wd, ra, ie, ack);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
